// File: rtl/lsu_pkg.sv
// Shared types and request-legality helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_H:  return addr_lo[0];
      SIZE_W:  return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal_size(input logic [1:0] size);
    return size == 2'b11;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data steering: load extract/extend and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       size,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] rdata,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] store_data
);

  function automatic logic [WIDTH-1:0] extend(input logic [1:0] sz, input logic uns,
                                              input logic [WIDTH-1:0] rd);
    case (sz)
      SIZE_B:  extend = {{(WIDTH-8){~uns & rd[7]}}, rd[7:0]};
      SIZE_H:  extend = {{(WIDTH-16){~uns & rd[15]}}, rd[15:0]};
      default: extend = rd;
    endcase
  endfunction

  // The RAM always writes four bytes, so untouched bytes are copied from the read.
  function automatic logic [WIDTH-1:0] merge(input logic [1:0] sz, input logic [WIDTH-1:0] rd,
                                             input logic [WIDTH-1:0] wd);
    case (sz)
      SIZE_B:  merge = {rd[WIDTH-1:8], wd[7:0]};
      SIZE_H:  merge = {rd[WIDTH-1:16], wd[15:0]};
      default: merge = wd;
    endcase
  endfunction

  assign load_data  = extend(size, is_unsigned, rdata);
  assign store_data = merge(size, rdata, wdata);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a byte-addressed little-endian RAM with 4-byte writes.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MEM_ADDR_W = 17
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [1:0]       req_size_i,
  input  logic             req_unsigned_i,
  input  logic [WIDTH-1:0] req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_rdata_o,
  output logic             rsp_err_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic [WIDTH-1:0] mem_rdata_i
);

  if (MEM_ADDR_W > WIDTH) begin : g_addr_w_check
    $error("MEM_ADDR_W must not exceed WIDTH");
  end

  lsu_state_t       state;
  logic             we_q;
  logic             unsigned_q;
  logic [1:0]       size_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] store_data;
  logic             req_err;

  assign req_err = is_illegal_size(req_size_i) | is_misaligned(req_size_i, req_addr_i[1:0]);

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .size       (size_q),
    .is_unsigned(unsigned_q),
    .rdata      (mem_rdata_i),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // Request attributes are pure data; only the FSM below needs reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && req_valid_i && req_ready_o) begin
      we_q       <= req_we_i;
      size_q     <= req_size_i;
      unsigned_q <= req_unsigned_i;
      wdata_q    <= req_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            req_ready_o <= 1'b0;
            if (req_err) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
            end else begin
              mem_addr_o <= req_addr_i;
              if (req_we_i && req_size_i == SIZE_W) begin
                state       <= WRITE;
                mem_we_o    <= 1'b1;
                mem_wdata_o <= req_wdata_i;
              end else begin
                state <= READ;
              end
            end
          end
        end
        // RAM read data is sampled here, at the end of the single READ cycle.
        READ: begin
          if (we_q) begin
            state       <= WRITE;
            mem_we_o    <= 1'b1;
            mem_wdata_o <= store_data;
          end else begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= load_data;
          end
        end
        WRITE: begin
          state       <= RESP;
          mem_we_o    <= 1'b0;
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= '0;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          mem_we_o    <= 1'b0;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-array RAM model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  ram [0:(1<<17)-1];
  logic        poke_en = 1'b0;
  logic [16:0] poke_addr = '0;
  logic [31:0] poke_data = '0;
  logic [16:0] ra;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.WIDTH(32), .MEM_ADDR_W(17)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_we_i      (req_we),
    .req_size_i    (req_size),
    .req_unsigned_i(req_unsigned),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata)
  );

  assign ra = mem_addr[16:0];
  assign mem_rdata = {ram[ra + 17'd3], ram[ra + 17'd2], ram[ra + 17'd1], ram[ra]};

  always @(posedge clk) begin
    if (poke_en) begin
      for (int k = 0; k < 4; k++) ram[poke_addr + 17'(k)] <= poke_data[8*k +: 8];
    end else if (mem_we) begin
      for (int k = 0; k < 4; k++) ram[ra + 17'(k)] <= mem_wdata[8*k +: 8];
    end
  end

  function automatic logic [31:0] peek(input logic [16:0] a);
    return {ram[a + 17'd3], ram[a + 17'd2], ram[a + 17'd1], ram[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [16:0] a, input logic [31:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    @(negedge clk);
    poke_en   = 1'b0;
  endtask

  // Issues one request and stops at the first negedge with rsp_valid high.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [7:0] we_hist, output logic [31:0] addr_n1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    lat = 99; we_hist = '0; addr_n1 = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (c == 1) addr_n1 = mem_addr;
      we_hist[c-1] = mem_we;
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  int          lat;
  logic [7:0]  wh;
  logic [31:0] a1;
  logic [31:0] held;

  initial begin
    rst = 1'b1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word load
    poke(17'h10000, 32'h12345678);
    do_req(1'b0, 2'b10, 1'b0, 32'h10000, 32'h0, lat, wh, a1);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_addr", a1, 32'h10000);
    check("lw_data", rsp_rdata, 32'h12345678);
    check("lw_err", 32'(rsp_err), 32'd0);
    check("lw_we", 32'(wh), 32'h0);
    consume();

    // Byte / half loads with extension
    poke(17'h10000, 32'h00008000);
    poke(17'h10010, 32'h00008001);
    do_req(1'b0, 2'b00, 1'b0, 32'h10001, 32'h0, lat, wh, a1);
    check("lb_lat", 32'(lat), 32'd2);
    check("lb_data", rsp_rdata, 32'hFFFFFF80);
    consume();
    do_req(1'b0, 2'b00, 1'b1, 32'h10001, 32'h0, lat, wh, a1);
    check("lbu_data", rsp_rdata, 32'h00000080);
    consume();
    do_req(1'b0, 2'b01, 1'b0, 32'h10010, 32'h0, lat, wh, a1);
    check("lh_data", rsp_rdata, 32'hFFFF8001);
    consume();
    do_req(1'b0, 2'b01, 1'b1, 32'h10010, 32'h0, lat, wh, a1);
    check("lhu_data", rsp_rdata, 32'h00008001);
    consume();

    // Sub-word stores (read-modify-write)
    poke(17'h10000, 32'h11223344);
    poke(17'h10004, 32'hCAFEF00D);
    do_req(1'b1, 2'b00, 1'b0, 32'h10002, 32'hDEADBEAB, lat, wh, a1);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_we_seq", 32'(wh), 32'h02);
    check("sb_rdata", rsp_rdata, 32'h0);
    check("sb_err", 32'(rsp_err), 32'd0);
    consume();
    check("sb_ram", peek(17'h10000), 32'h11AB3344);
    check("sb_ram_next", peek(17'h10004), 32'hCAFEF00D);
    do_req(1'b0, 2'b10, 1'b0, 32'h10000, 32'h0, lat, wh, a1);
    check("sb_readback", rsp_rdata, 32'h11AB3344);
    consume();
    do_req(1'b1, 2'b01, 1'b0, 32'h10000, 32'h1234BEEF, lat, wh, a1);
    check("sh_lat", 32'(lat), 32'd3);
    consume();
    check("sh_ram", peek(17'h10000), 32'h11ABBEEF);

    // Word store
    do_req(1'b1, 2'b10, 1'b0, 32'h10008, 32'h55667788, lat, wh, a1);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_we_seq", 32'(wh), 32'h01);
    consume();
    check("sw_ram", peek(17'h10008), 32'h55667788);

    // Error cases: no memory access, response after one cycle
    do_req(1'b1, 2'b01, 1'b0, 32'h10001, 32'h0000FFFF, lat, wh, a1);
    check("err_sh_lat", 32'(lat), 32'd1);
    check("err_sh_err", 32'(rsp_err), 32'd1);
    check("err_sh_rdata", rsp_rdata, 32'h0);
    check("err_sh_we", 32'(wh), 32'h0);
    consume();
    do_req(1'b1, 2'b10, 1'b0, 32'h10002, 32'hFFFFFFFF, lat, wh, a1);
    check("err_sw_lat", 32'(lat), 32'd1);
    check("err_sw_err", 32'(rsp_err), 32'd1);
    check("err_sw_we", 32'(wh), 32'h0);
    consume();
    check("err_ram", peek(17'h10000), 32'h11ABBEEF);
    do_req(1'b0, 2'b11, 1'b0, 32'h10000, 32'h0, lat, wh, a1);
    check("err_size11", 32'(rsp_err), 32'd1);
    consume();
    do_req(1'b0, 2'b10, 1'b0, 32'h10001, 32'h0, lat, wh, a1);
    check("err_lw_mis", 32'(rsp_err), 32'd1);
    consume();

    // Response backpressure
    do_req(1'b0, 2'b10, 1'b0, 32'h10008, 32'h0, lat, wh, a1);
    check("bp_lat", 32'(lat), 32'd2);
    held = rsp_rdata;
    check("bp_data", held, 32'h55667788);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_stable", rsp_rdata, held);
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    consume();
    check("bp_rel_valid", 32'(rsp_valid), 32'd0);
    check("bp_rel_ready", 32'(req_ready), 32'd1);

    // Reset during the WRITE of a sub-word store
    poke(17'h10020, 32'h01020304);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10020; req_wdata = 32'h000000EE;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst6_read_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    check("rst6_write_we", 32'(mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst6_we_async", 32'(mem_we), 32'd0);
    check("rst6_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst6_ready", 32'(req_ready), 32'd1);
    check("rst6_rsp", 32'(rsp_valid), 32'd0);
    check("rst6_ram", peek(17'h10020), 32'h01020304);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
